riscv_pipeline_ctrl: RTL
========================

# riscv_pipeline_ctrl

Pipeline control sequencer for the 5-stage RISC-V core. It consumes the hazard unit's `load_use_hazard` together with the EX-stage redirect, instruction-fetch and data-memory handshakes, and multi-cycle busy status. From these it drives the per-stage register write-enables and flushes, the PC write-enable and the redirect select. It also runs the post-reset pipeline drain, squashes wrong-path fetch responses, and keeps saturating stall and flush performance counters.

## Interface
Parameters:
- `INIT_CYCLES`, default 2: cycles of full-pipeline flush after reset, range 1–15.
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `load_use_hazard` in 1: load in EX feeds an instruction in ID.
- `ex_redirect` in 1: branch taken or jump resolved in EX.
- `ex_busy` in 1: multi-cycle op occupies EX.
- `if_pending` in 1: instruction fetch outstanding.
- `imem_ready` in 1: fetch response valid this cycle.
- `mem_req` in 1: MEM stage holds a load or store.
- `mem_ready` in 1: data memory acknowledges.
- `pc_we` out 1: PC register update.
- `pc_sel_redirect` out 1: PC loads the EX target instead of PC+4.
- `if_id_we`, `id_ex_we`, `ex_mem_we`, `mem_wb_we` out 1 each: stage register enables.
- `if_id_flush`, `id_ex_flush`, `ex_mem_flush`, `mem_wb_flush` out 1 each: load a bubble into the stage register; flush takes precedence over hold.
- `stall_cycles` out CNT_W: saturating count of cycles with `pc_we`=0 in RUN or DISCARD.
- `flush_events` out CNT_W: saturating count of accepted redirects.

## Operation
- FSM states: INIT, RUN, DISCARD. Encoded as `pctl_state_t`.
- **INIT**
  - Entered on reset.
  - All flushes are 1 and all enables are 0.
  - A down-counter loads `INIT_CYCLES-1` and decrements each cycle. At 0 the FSM moves to RUN.
- **RUN and DISCARD stall resolution** is evaluated in strict priority order:
  1. `mem_stall` = `mem_req & ~mem_ready`.
     - All `*_we`=0 and `pc_we`=0.
     - `mem_wb_flush`=1.
     - No redirect is accepted.
  2. `ex_busy`.
     - `pc_we`, `if_id_we`, `id_ex_we` = 0.
     - `ex_mem_flush`=1 and `mem_wb_we`=1.
     - `ex_redirect` is ignored.
  3. `ex_redirect`.
     - `pc_we`=1 and `pc_sel_redirect`=1.
     - `if_id_flush`=1 and `id_ex_flush`=1.
     - Remaining enables are 1.
     - `flush_events` increments.
     - A coincident `load_use_hazard` is ignored because the ID instruction is wrong-path.
  4. `load_use_hazard`.
     - `pc_we`=0 and `if_id_we`=0.
     - `id_ex_flush`=1.
     - `ex_mem_we` and `mem_wb_we` are 1.
  5. Fetch stall (`if_pending & ~imem_ready`).
     - `pc_we`=0.
     - `if_id_flush`=1.
     - Downstream enables are 1.
  6. Otherwise all enables are 1 and all flushes are 0.
- **RUN → DISCARD**: taken when a redirect is accepted while `if_pending & ~imem_ready`, because the outstanding fetch is wrong-path.
- **In DISCARD**
  - `if_id_flush` is forced to 1 every cycle; the priority rules above still apply otherwise.
  - On the cycle `imem_ready`=1 the response is squashed and the FSM moves to RUN.
  - A new accepted redirect in DISCARD stays in DISCARD and keeps waiting.
  - `mem_stall` does not block the exit.
- **Counters**
  - Saturate at all-ones and never wrap.
  - Frozen during INIT.
  - Cleared only by reset.

## Timing
- **Reset values.** While `rst_n`=0 at a clock edge:
  - state becomes INIT and both counters become 0.
  - Outputs, which follow from INIT, are: flushes 1, enables 0, `pc_sel_redirect` 0.
- **Mid-operation reset.** Reset asserted at any time re-enters INIT on the next edge and restarts the full `INIT_CYCLES` drain.
- **Output timing.** Control outputs are combinational from the current state and inputs, giving zero-cycle stall response.
- **Register timing.** State and counters update on the rising edge, so counter values reflect the previous cycle's events.
- **First enable.** The first cycle with `pc_we`=1 is exactly `INIT_CYCLES` cycles after `rst_n` rises.
- **Load-use bubble.** A single-cycle `load_use_hazard` produces exactly one bubble. The hazard unit de-asserts it the next cycle once the load reaches MEM.
- **Combinational paths.** No path from any `*_we` output back to an input; the parent must not create a loop through `load_use_hazard`.

## Structure
- `riscv_pkg` holds:
  - `typedef enum logic [1:0] {PCTL_INIT, PCTL_RUN, PCTL_DISCARD} pctl_state_t`
  - localparam `PCTL_INIT_W`=4 for the drain counter width.
- Sub-module `riscv_sat_counter`, parameterised width, with inputs `clk`, `rst_n`, `inc` and output `count`. It is instantiated twice, once per performance counter.
- FSM and priority logic live in the top module.

## Test plan
- **Reset drain.** Hold `rst_n`=0 for 3 cycles, then release with `INIT_CYCLES`=2 → flushes held 1 for 2 cycles, `pc_we`=1 on cycle 3, counters 0.
- **Load-use.** Pulse `load_use_hazard` for 1 cycle in RUN → that cycle `pc_we`=0, `if_id_we`=0, `id_ex_flush`=1; next cycle all enables 1; `stall_cycles`=1.
- **Redirect beats load-use.** Assert `ex_redirect` and `load_use_hazard` together → `pc_sel_redirect`=1, `if_id_flush`=`id_ex_flush`=1, `pc_we`=1; `flush_events`=1.
- **Wrong-path discard.** Assert `ex_redirect` with `if_pending`=1 and `imem_ready`=0, then raise `imem_ready` 3 cycles later → DISCARD is held and `if_id_flush`=1 throughout; the response is squashed; RUN resumes the following cycle.
- **Memory stall dominance.** Hold `mem_req`=1 and `mem_ready`=0 for 4 cycles with `ex_redirect`=1 → all enables 0, `mem_wb_flush`=1, no redirect accepted, `stall_cycles`=4. After `mem_ready` rises, the redirect is accepted on that cycle.
- **Saturation.** With `CNT_W`=4, apply 20 stall cycles → `stall_cycles`=15, holds at 15.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types for the RISC-V pipeline control slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_pkg;

  typedef enum logic [1:0] {
    PCTL_INIT,
    PCTL_RUN,
    PCTL_DISCARD
  } pctl_state_t;

  // Width of the post-reset drain counter; holds INIT_CYCLES-1 for INIT_CYCLES up to 15.
  localparam int PCTL_INIT_W = 4;

endpackage

// File: rtl/riscv_sat_counter.sv
// Saturating up-counter for pipeline performance statistics.
// Latency: count reflects an inc one cycle after it is sampled.
// Backpressure: none; holds at all-ones instead of wrapping.
// Ports: clk, rst_n (sync, active-low), inc (count this cycle), count (current value).
module riscv_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/riscv_pipeline_ctrl.sv
// Pipeline control sequencer: stage enables/flushes, PC update, drain and wrong-path squash.
// Latency: control outputs are combinational (zero-cycle); state and counters update on the edge.
// Backpressure: memory stall freezes everything; EX busy, load-use and fetch stalls hold the front end.
// Ports: hazard/redirect/handshake status in; pc_we, pc_sel_redirect, per-stage *_we and *_flush out;
//        stall_cycles and flush_events saturating counters out.
module riscv_pipeline_ctrl
  import riscv_pkg::*;
#(
  parameter int INIT_CYCLES = 2,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_use_hazard,
  input  logic             ex_redirect,
  input  logic             ex_busy,
  input  logic             if_pending,
  input  logic             imem_ready,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             pc_sel_redirect,
  output logic             if_id_we,
  output logic             id_ex_we,
  output logic             ex_mem_we,
  output logic             mem_wb_we,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam logic [PCTL_INIT_W-1:0] INIT_LOAD = PCTL_INIT_W'(INIT_CYCLES - 1);

  pctl_state_t            state;
  pctl_state_t            state_nxt;
  logic [PCTL_INIT_W-1:0] init_cnt;

  logic mem_stall;
  logic fetch_stall;
  logic redirect_acc;
  logic stall_inc;

  assign mem_stall   = mem_req & ~mem_ready;
  assign fetch_stall = if_pending & ~imem_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= PCTL_INIT;
      init_cnt <= INIT_LOAD;
    end else begin
      state <= state_nxt;
      if ((state == PCTL_INIT) && (init_cnt != '0)) begin
        init_cnt <= init_cnt - PCTL_INIT_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt       = state;
    pc_we           = 1'b1;
    pc_sel_redirect = 1'b0;
    if_id_we        = 1'b1;
    id_ex_we        = 1'b1;
    ex_mem_we       = 1'b1;
    mem_wb_we       = 1'b1;
    if_id_flush     = 1'b0;
    id_ex_flush     = 1'b0;
    ex_mem_flush    = 1'b0;
    mem_wb_flush    = 1'b0;
    redirect_acc    = 1'b0;

    if (state == PCTL_INIT) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_ex_we     = 1'b0;
      ex_mem_we    = 1'b0;
      mem_wb_we    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      mem_wb_flush = 1'b1;
      if (init_cnt == '0) begin
        state_nxt = PCTL_RUN;
      end
    end else begin
      // Stages that are not held keep their enable high; a flush on an enabled
      // stage loads a bubble.
      if (mem_stall) begin
        pc_we        = 1'b0;
        if_id_we     = 1'b0;
        id_ex_we     = 1'b0;
        ex_mem_we    = 1'b0;
        mem_wb_we    = 1'b0;
        mem_wb_flush = 1'b1;
      end else if (ex_busy) begin
        pc_we        = 1'b0;
        if_id_we     = 1'b0;
        id_ex_we     = 1'b0;
        ex_mem_flush = 1'b1;
      end else if (ex_redirect) begin
        // The ID instruction is wrong-path, so a coincident load-use is moot.
        redirect_acc    = 1'b1;
        pc_sel_redirect = 1'b1;
        if_id_flush     = 1'b1;
        id_ex_flush     = 1'b1;
      end else if (load_use_hazard) begin
        pc_we       = 1'b0;
        if_id_we    = 1'b0;
        id_ex_flush = 1'b1;
      end else if (fetch_stall) begin
        pc_we       = 1'b0;
        if_id_flush = 1'b1;
      end

      if (state == PCTL_DISCARD) begin
        // Whatever the outstanding fetch returns is wrong-path; never let it into ID.
        if_id_flush = 1'b1;
        if (imem_ready) begin
          state_nxt = PCTL_RUN;
        end
      end else if (redirect_acc && fetch_stall) begin
        state_nxt = PCTL_DISCARD;
      end
    end
  end

  assign stall_inc = (state != PCTL_INIT) & ~pc_we;

  riscv_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .count (stall_cycles)
  );

  riscv_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (redirect_acc),
    .count (flush_events)
  );

endmodule
